// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor. It computes a - b one bit per
//               clock, LSB first, through a single full-subtractor cell. The
//               result is published with a one-cycle done pulse after WIDTH
//               RUN cycles.
//               Optional feature macro: SERIAL_SUB_OVF_EN. When it is defined,
//               a signed-overflow flag output named ovf is added.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // The bit counter needs at least one bit, even when WIDTH is 1.
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
`ifdef SERIAL_SUB_OVF_EN
    // The shifting registers lose the operand sign bits, so keep them here.
    logic             a_msb;
    logic             b_msb;
`endif

    logic             bit_d;
    logic             bit_br;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs. The new difference bit is
    // shifted in at the MSB end, so after WIDTH steps the result is aligned.
    always_comb begin
        bit_d    = a_sh[0] ^ b_sh[0] ^ br;
        bit_br   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_cat  = {bit_d, res_sh};
        res_next = res_cat[WIDTH:1];
    end

    // Control FSM with datapath and registered outputs. The published result
    // changes only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= bit_br;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        diff   <= res_next;
                        borrow <= bit_br;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 Port: a  input  WIDTH  minuend; sampled only when start is accepted.
REQ-007 Port: b  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when a result is produced.
REQ-010 Port: diff  output  WIDTH  result a - b, modulo 2^WIDTH.
REQ-011 Port: borrow  output  1  high when a < b as unsigned values.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE; on acceptance, a and b SHALL be latched, the internal borrow flop and bit counter SHALL be cleared, and the FSM SHALL enter RUN.
REQ-014 start while busy=1 SHALL be ignored, with no effect on the operands, state or outputs.
REQ-015 In RUN, one bit per cycle SHALL be processed LSB-first, using the full-subtractor cell d = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 RUN SHALL last exactly WIDTH cycles; after the last bit, the FSM SHALL enter DONE.
REQ-017 On entry to DONE, diff and borrow SHALL be updated from the internal shift register and the final borrow, and done SHALL assert for exactly that one cycle.
REQ-018 DONE SHALL always last exactly one cycle; the next state SHALL be RUN if start is accepted in that cycle, otherwise IDLE.
REQ-019 Latency: with start accepted at edge N, done SHALL be high in the cycle after edge N+WIDTH.
REQ-020 diff and borrow SHALL hold the last completed result and SHALL stay stable during RUN; partial results SHALL NOT be visible.
REQ-021 busy SHALL be 1 exactly while in RUN.
REQ-022 With WIDTH=1, the block SHALL behave as a registered half subtractor: diff=a^b and borrow=~a&b.

Reset
REQ-023 Asserting rst_n low SHALL immediately force IDLE, with busy=0, done=0, diff=0, borrow=0 (ovf=0 when present), and clear all internal registers.
REQ-024 Reset during RUN SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-025 The first start SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN: when defined, an extra output port ovf (output, 1 bit) SHALL exist and update together with diff.
REQ-027 ovf SHALL be computed as (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) on the latched operands, flagging two's-complement signed overflow.
REQ-028 When SERIAL_SUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, start at edge 0 -> done high after edge 8, diff=0x02, borrow=0, busy high for 8 cycles.
REQ-030 WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, borrow=1; and a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-031 WIDTH=8, start pulsed again at cycle 3 of RUN with different operands -> ignored; the first result is unchanged; back-to-back start in the DONE cycle -> second result follows after a further 8 cycles.
REQ-032 rst_n low at RUN cycle 4 -> outputs zero at once, no done pulse; a new start after release completes normally.
REQ-033 WIDTH=1, all four a/b combinations -> diff/borrow = 0/0, 1/0, 1/1, 0/0 for (0,0), (1,0), (0,1), (1,1).
REQ-034 SERIAL_SUB_OVF_EN defined, WIDTH=8, a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; and a=0x10, b=0x01 -> ovf=0.
